store_merge_unit: RTL
=====================

Name: store_merge_unit

Overview:
Store-side counterpart to the load width/sign-extension path. It accepts a store request (SB/SH/SW by funct3) and writes it into a word-wide data memory that has no byte enables. SW is written directly. SB/SH use a read-modify-write sequence that merges the new byte or halfword into the existing word. It sits between the multicycle datapath's store request and the data memory port.

Parameters:
READ_LAT, 1, cycles from mem_re assertion to valid mem_rdata (legal range 1..4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  store request; sampled only in IDLE
funct3  input  3  store width: 000 SB, 001 SH, 010 SW
addr  input  32  byte address of the store
wdata  input  32  store data (SB uses [7:0], SH uses [15:0])
mem_rdata  input  32  memory read data, valid READ_LAT cycles after mem_re
mem_addr  output  32  word-aligned address ({addr_q[31:2],2'b00})
mem_re  output  1  one-cycle read strobe
mem_we  output  1  one-cycle write strobe
mem_wdata  output  32  word to write
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse
misaligned  output  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset: state=IDLE; mem_re, mem_we, done, misaligned, busy = 0; mem_addr, mem_wdata, internal regs = 0. Reset mid-operation aborts immediately; no write strobe is ever issued after reset is asserted.
- Capture: on start in IDLE, latch addr_q, wdata_q and funct3_q. start in any other state is ignored (no queueing).
- Classification at capture:
  - funct3 not in {000,001,010} -> ERR.
  - SH with addr[0]=1 -> ERR.
  - SW with addr[1:0]!=0 -> ERR.
  - SW aligned -> WRITE.
  - SB or aligned SH -> READ.
- States:
  - IDLE: waits for start.
  - READ: mem_re=1 for exactly one cycle; wait counter loaded with READ_LAT-1; next state WAIT.
  - WAIT: counter decrements each cycle. When the counter is 0, capture mem_rdata into old_q; next state WRITE.
  - WRITE: mem_we=1, done=1; next state IDLE.
  - ERR: done=1, misaligned=1, mem_we=0; next state IDLE.
- Merge (registered; valid in WRITE):
  - SW: mem_wdata = wdata_q.
  - SB, off=addr_q[1:0]: replace byte lane off of old_q with wdata_q[7:0]. Lane 0 = [7:0], lane 3 = [31:24]. Other lanes are unchanged.
  - SH off=0: {old_q[31:16], wdata_q[15:0]}.
  - SH off=2: {wdata_q[15:0], old_q[15:0]}.
  - wdata_q bits above the store width are ignored.
- mem_addr holds the word address from the cycle after capture until the return to IDLE, and is unchanged in IDLE.
- Latency, with start accepted at cycle 0:
  - SW: mem_we/done at cycle 1.
  - SB/SH: mem_re at cycle 1; capture at cycle 1+READ_LAT; mem_we/done at cycle 2+READ_LAT.
  - ERR: done at cycle 1.
- Back-to-back: start may be accepted in the IDLE cycle immediately following done. busy=0 in that cycle.
- mem_re and mem_we are never high in the same cycle.

Test Plan:
- Reset, then SW addr=0x100, wdata=0xDEADBEEF -> cycle 1: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_re never asserted.
- READ_LAT=1, memory word 0x11223344; SB addr=0x202, wdata=0xFFFFFFAB -> mem_re at cycle 1 (mem_addr=0x200); mem_we at cycle 3 with mem_wdata=0x11AB3344.
- SH addr=0x302, wdata=0x0000BEEF, old word 0xCAFEF00D -> mem_wdata=0xBEEFF00D. Then SH addr=0x300, same data and old word -> 0xCAFEBEEF.
- Misaligned: SH addr=0x3 and SW addr=0x2 -> each gives done=1 and misaligned=1 at cycle 1 with no mem_we/mem_re. funct3=011 -> same error response.
- Assert reset in the WAIT state of an SB -> next cycle IDLE, all outputs 0, no mem_we. A subsequent SW completes normally.
- READ_LAT=3; start held high continuously; two SBs -> second accepted only in the IDLE cycle after the first done. Each write occurs at cycle 5 relative to its acceptance. The start pulse arriving during busy is dropped.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit
//   Turns SB/SH/SW store requests into whole-word writes for a data memory
//   that has no byte enables. SW goes straight to a write. SB/SH read the
//   old word, merge the new byte/halfword into it and write it back.
//   Misaligned stores and unknown funct3 codes finish with an error pulse
//   and never touch memory.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           store request, only looked at while idle
//   funct3          000 SB, 001 SH, 010 SW, anything else is an error
//   addr, wdata     byte address and store data of the request
//   mem_rdata       memory read data, valid READ_LAT cycles after mem_re
//   mem_addr        word-aligned address of the captured request
//   mem_re, mem_we  one-cycle read / write strobes
//   mem_wdata       word written on mem_we
//   busy            high whenever not idle
//   done            one-cycle completion pulse
//   misaligned      one-cycle error pulse, coincident with done
//
// state  | meaning
// IDLE   | waiting for start
// READ   | mem_re strobe, wait counter loaded
// WAIT   | counting down the read latency, capture/merge at zero
// WRITE  | mem_we strobe with merged word, done
// ERR    | done + misaligned, no memory access
module store_merge_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int CNT_W = 2;

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      old_q, old_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  // Insert the store data into the old word; only the lane(s) selected by
  // the byte offset change, bits of wd above the store width are dropped.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  off);
    logic [31:0] res;
    res = old;
    if (f3 == F3_SB) begin
      case (off)
        2'd0: res = {old[31:8], wd[7:0]};
        2'd1: res = {old[31:16], wd[7:0], old[7:0]};
        2'd2: res = {old[31:24], wd[7:0], old[15:0]};
        default: res = {wd[7:0], old[23:0]};
      endcase
    end else if (f3 == F3_SH) begin
      res = off[1] ? {wd[15:0], old[15:0]} : {old[31:16], wd[15:0]};
    end else begin
      res = wd;
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    cnt_d       = cnt_q;
    old_d       = old_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = addr;
          wdata_d  = wdata;
          funct3_d = funct3;
          case (funct3)
            F3_SB: state_d = S_READ;
            F3_SH: state_d = addr[0] ? S_ERR : S_READ;
            F3_SW: begin
              if (addr[1:0] != 2'b00) begin
                state_d = S_ERR;
              end else begin
                state_d     = S_WRITE;
                mem_wdata_d = wdata;
              end
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_READ: begin
        cnt_d   = CNT_W'(READ_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          old_d       = mem_rdata;
          mem_wdata_d = merge(mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
          state_d     = S_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      cnt_q       <= '0;
      old_q       <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      cnt_q       <= cnt_d;
      old_q       <= old_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Strobes are masked by reset so an abort in the WRITE cycle can never
  // leak a write to memory.
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign mem_re     = (state_q == S_READ) && !reset;
  assign mem_we     = (state_q == S_WRITE) && !reset;
  assign done       = ((state_q == S_WRITE) || (state_q == S_ERR)) && !reset;
  assign misaligned = (state_q == S_ERR) && !reset;

  // old_q is kept as a debug view of the last word read back.
  logic unused_old;
  assign unused_old = ^old_q;

endmodule
